// File: rtl/counter_seq_ctrl.sv
// Run-control sequencer for a terminal-count counter with a programmable prescaler.
// Provides launch/stop/pause/resume control, one-shot or auto-reload modes, and a wrap carry pulse.
module counter_seq_ctrl #(
  parameter int N       = 4,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [N-1:0]       load_val,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               auto_reload,
  output logic [N-1:0]       qout,
  output logic               cout,
  output logic               tick_en,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       qout_q, qout_d;
  logic [N-1:0]       term_q, term_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               mode_q, mode_d;
  logic               cout_q, cout_d;

  // Deliberately left unmasked by stop: the advance is discarded in the next-state logic instead.
  assign tick_en = (state_q == ST_RUN) && (presc_cnt_q == presc_q);

  always_comb begin
    // NOTE: every variable gets a default here so no path through the case infers a latch.
    state_d     = state_q;
    qout_d      = qout_q;
    term_d      = term_q;
    presc_cnt_d = presc_cnt_q;
    presc_d     = presc_q;
    mode_d      = mode_q;
    cout_d      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_d     = ST_IDLE;
          qout_d      = '0;
          presc_cnt_d = '0;
        end else if (start) begin
          state_d     = ST_RUN;
          qout_d      = '0;
          presc_cnt_d = '0;
          term_d      = load_val;
          presc_d     = prescale;
          mode_d      = auto_reload;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d     = ST_IDLE;
          qout_d      = '0;
          presc_cnt_d = '0;
        end else begin
          if (tick_en) begin
            presc_cnt_d = '0;
            if (qout_q == term_q) begin
              qout_d = '0;
              cout_d = 1'b1;
              if (!mode_q) state_d = ST_DONE;
            end else begin
              qout_d = qout_q + N'(1);
            end
          end else begin
            presc_cnt_d = presc_cnt_q + PRESC_W'(1);
          end
          // A one-shot that just finished stays DONE; pausing it would allow a second pass.
          if (!start && pause && state_d == ST_RUN) state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (stop) begin
          state_d     = ST_IDLE;
          qout_d      = '0;
          presc_cnt_d = '0;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (reset) begin
      state_q     <= ST_IDLE;
      qout_q      <= '0;
      term_q      <= '0;
      presc_cnt_q <= '0;
      presc_q     <= '0;
      mode_q      <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      qout_q      <= qout_d;
      term_q      <= term_d;
      presc_cnt_q <= presc_cnt_d;
      presc_q     <= presc_d;
      mode_q      <= mode_d;
      cout_q      <= cout_d;
    end
  end

  assign qout  = qout_q;
  assign cout  = cout_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign state = state_q;

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Run-control sequencer for the team's binary counters. It owns a terminal-count counter and a programmable prescaler, and provides start, stop, pause and resume control. It supports one-shot or auto-reload modes and emits a one-cycle carry pulse on each wrap. It sits between the user-control inputs (buttons or register bits) and the counter datapath, so the top level can run the counter as a timed sequence instead of free-running.

Parameters:
N, 4, counter width in bits (qout, load_val).
PRESC_W, 8, prescaler width in bits.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  level-sampled; launches from IDLE/DONE, resumes from PAUSE.
stop  input  1  level-sampled; abort to IDLE.
pause  input  1  level-sampled; freeze in RUN.
load_val  input  N  terminal count, latched on launch.
prescale  input  PRESC_W  count advances once every (prescale+1) cycles; latched on launch.
auto_reload  input  1  1 = wrap and keep running; 0 = one-shot; latched on launch.
qout  output  N  current count.
cout  output  1  one-cycle pulse on terminal wrap.
tick_en  output  1  combinational; high in the cycle the count will advance.
busy  output  1  high while state is RUN.
done  output  1  high while state is DONE.
state  output  2  encoding: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - state=IDLE; qout=0; cout=0; prescaler=0.
  - term, presc and mode registers cleared to 0.
  - busy=0; done=0; tick_en=0.
- Command priority in every state: reset > stop > start > pause.
- Launch (start in IDLE or DONE):
  - Next edge: state=RUN; qout=0; prescaler=0.
  - term<=load_val; presc<=prescale; mode<=auto_reload.
  - First count advance occurs presc+1 cycles after entering RUN.
- tick_en = (state==RUN) && (prescaler==presc). It is not masked by same-cycle stop.
- RUN, prescaler behaviour:
  - tick_en=0: prescaler increments.
  - tick_en=1: prescaler returns to 0.
- RUN, on a tick edge:
  - qout!=term: qout<=qout+1; cout<=0.
  - qout==term: qout<=0 and cout<=1 for exactly the following cycle. If mode=1, stay in RUN; if mode=0, go to DONE.
- cout is registered. It is 0 in every cycle except the one following a terminal tick.
- term=0: every tick is terminal. qout stays 0 and cout pulses once per tick.
- Wrap arithmetic is modulo 2^N. term=2^N-1 gives a full-range count; no overflow beyond term is possible.
- RUN + pause (no stop):
  - A same-cycle tick is processed first.
  - Then state=PAUSE; qout and prescaler hold.
- RUN + start: ignored; no restart.
- PAUSE:
  - All counters hold; tick_en=0; cout=0.
  - start: back to RUN, continuing from the held qout and prescaler; latched config is unchanged.
  - stop: go to IDLE.
- stop from RUN, PAUSE or DONE: next edge state=IDLE, qout=0, prescaler=0, cout=0. A same-cycle tick is discarded.
- DONE: qout=0; done=1; counting halted. start relaunches; stop goes to IDLE.
- IDLE: qout=0; pause and stop are no-ops.
- Inputs load_val, prescale and auto_reload changing outside a launch edge have no effect.
- Reset asserted mid-RUN overrides all commands on that edge.

Test Plan:
1. N=4, prescale=0, load_val=5, auto_reload=0; pulse start -> qout=1,2,3,4,5 on edges 2-6 after start, then qout=0 with cout=1 for one cycle, state=DONE, done=1; qout stays 0 afterward.
2. prescale=2, load_val=3, auto_reload=1 -> qout advances every 3 cycles (0,1,2,3,0,...); cout pulses every 12 cycles; state remains RUN.
3. load_val=4, prescale=0; assert pause 2 cycles after start for 5 cycles, then pulse start -> qout=2 held with tick_en=0 during PAUSE; resumes 3,4,0 with cout=1, ending in DONE.
4. Assert start+stop together in RUN, then stop alone when qout=3 -> stop wins; state=IDLE, qout=0, cout never asserted.
5. load_val=0, auto_reload=1, prescale=1 -> qout constantly 0; cout pulses every 2 cycles.
6. Assert reset while RUN with qout=7, N=4, load_val=15 -> next edge all outputs 0, state=IDLE; a subsequent start launches normally.
